// File: rtl/factory_slot_allocator.sv
// Slot pool allocator: round-robin requester arbitration, lowest-free-slot grant, release port, query port.
// Optional statistics counters are compiled in with `define FACTORY_ALLOC_STATS_EN.
module factory_slot_allocator #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 8,
    parameter int KIND_W    = 2,
    parameter int ID_W      = $clog2(NUM_SLOTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*KIND_W-1:0] req_kind,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [ID_W-1:0]           gnt_id,
    output logic [KIND_W-1:0]         gnt_kind,
    input  logic                      rel_valid,
    input  logic [ID_W-1:0]           rel_id,
    output logic                      rel_err,
    input  logic [ID_W-1:0]           qry_id,
    output logic [KIND_W-1:0]         qry_kind,
    output logic                      qry_used,
    output logic [ID_W:0]             free_count,
    output logic                      full
`ifdef FACTORY_ALLOC_STATS_EN
    ,
    output logic [15:0]               stat_grants,
    output logic [15:0]               stat_stalls
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_win;
    logic [NUM_SLOTS-1:0] r_used;
    logic [KIND_W-1:0]   r_kind [NUM_SLOTS];
    logic [NUM_REQ-1:0]  r_req_ack;
    logic [ID_W-1:0]     r_gnt_id;
    logic [KIND_W-1:0]   r_gnt_kind;
    logic                r_rel_err;

    logic [PTR_W-1:0]    w_win_id;
    logic [KIND_W-1:0]   w_win_kind;
    logic [ID_W-1:0]     w_free_id;
    logic [ID_W:0]       w_used_cnt;
    logic                w_rel_in;
    logic                w_rel_ok;
    logic                w_qry_in;

    // NOTE: every variable gets a default before the loops, so no latch is inferred.
    always_comb begin : winner_pick
        int idx;
        logic found;
        found      = 1'b0;
        w_win_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                w_win_id = PTR_W'(idx);
            end
        end
        w_win_kind = req_kind[int'(w_win_id)*KIND_W +: KIND_W];
    end

    always_comb begin
        w_free_id  = '0;
        w_used_cnt = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!r_used[s]) w_free_id = ID_W'(s);
            w_used_cnt = w_used_cnt + (ID_W+1)'(r_used[s]);
        end
    end

    assign w_rel_in   = {1'b0, rel_id} < (ID_W+1)'(NUM_SLOTS);
    assign w_rel_ok   = w_rel_in && r_used[rel_id];
    assign w_qry_in   = {1'b0, qry_id} < (ID_W+1)'(NUM_SLOTS);
    assign free_count = (ID_W+1)'(NUM_SLOTS) - w_used_cnt;
    assign full       = (free_count == '0);

    // NOTE: sequential state uses non-blocking assignments only; the slot table is reset
    // because a freshly reset pool must read back kind 0 everywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_win      <= '0;
            r_used     <= '0;
            r_req_ack  <= '0;
            r_gnt_id   <= '0;
            r_gnt_kind <= '0;
            r_rel_err  <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) r_kind[s] <= '0;
        end else begin
            r_req_ack <= '0;
            r_rel_err <= 1'b0;
            if (rel_valid) begin
                if (w_rel_ok) begin
                    r_used[rel_id] <= 1'b0;
                    r_kind[rel_id] <= '0;
                end else begin
                    r_rel_err <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (|req_valid && !full) begin
                        r_state    <= S_GRANT;
                        r_win      <= w_win_id;
                        r_req_ack  <= NUM_REQ'(1) << w_win_id;
                        r_gnt_id   <= w_free_id;
                        r_gnt_kind <= w_win_kind;
                    end
                end
                S_GRANT: begin
                    // The granted slot was free when latched, so a same-cycle release cannot target it.
                    r_used[r_gnt_id] <= 1'b1;
                    r_kind[r_gnt_id] <= r_gnt_kind;
                    r_rr_ptr         <= (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + PTR_W'(1);
                    r_state          <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A reset landing in the grant cycle cancels the handshake along with the slot update.
    assign req_ack  = rst ? '0 : r_req_ack;
    assign gnt_id   = r_gnt_id;
    assign gnt_kind = r_gnt_kind;
    assign rel_err  = r_rel_err;
    assign qry_used = w_qry_in && r_used[qry_id];
    assign qry_kind = qry_used ? r_kind[qry_id] : '0;

`ifdef FACTORY_ALLOC_STATS_EN
    logic [15:0] r_stat_grants;
    logic [15:0] r_stat_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_grants <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (r_state == S_GRANT && r_stat_grants != 16'hFFFF)
                r_stat_grants <= r_stat_grants + 16'd1;
            if (r_state == S_IDLE && |req_valid && full && r_stat_stalls != 16'hFFFF)
                r_stat_stalls <= r_stat_stalls + 16'd1;
        end
    end

    assign stat_grants = r_stat_grants;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_factory_slot_allocator.sv
// Scoreboard bench for factory_slot_allocator: directed grant/release/reset scenarios,
// plus a 6-slot instance covering out-of-range release ids.
module tb_factory_slot_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [7:0] req_kind;
    logic [3:0] req_ack;
    logic [2:0] gnt_id;
    logic [1:0] gnt_kind;
    logic       rel_valid;
    logic [2:0] rel_id;
    logic       rel_err;
    logic [2:0] qry_id;
    logic [1:0] qry_kind;
    logic       qry_used;
    logic [3:0] free_count;
    logic       full;

    logic       rel_valid6;
    logic [2:0] rel_id6;
    logic [3:0] req_ack6;
    logic [2:0] gnt_id6;
    logic [1:0] gnt_kind6;
    logic       rel_err6;
    logic [1:0] qry_kind6;
    logic       qry_used6;
    logic [3:0] free_count6;
    logic       full6;
`ifdef FACTORY_ALLOC_STATS_EN
    logic [15:0] stat_grants, stat_stalls, stat_grants6, stat_stalls6;
`endif

    factory_slot_allocator #(.NUM_REQ(4), .NUM_SLOTS(8), .KIND_W(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_kind(req_kind),
        .req_ack(req_ack), .gnt_id(gnt_id), .gnt_kind(gnt_kind),
        .rel_valid(rel_valid), .rel_id(rel_id), .rel_err(rel_err),
        .qry_id(qry_id), .qry_kind(qry_kind), .qry_used(qry_used),
        .free_count(free_count), .full(full)
`ifdef FACTORY_ALLOC_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    factory_slot_allocator #(.NUM_REQ(4), .NUM_SLOTS(6), .KIND_W(2)) u_dut6 (
        .clk(clk), .rst(rst), .req_valid(4'b0000), .req_kind(8'h00),
        .req_ack(req_ack6), .gnt_id(gnt_id6), .gnt_kind(gnt_kind6),
        .rel_valid(rel_valid6), .rel_id(rel_id6), .rel_err(rel_err6),
        .qry_id(3'd0), .qry_kind(qry_kind6), .qry_used(qry_used6),
        .free_count(free_count6), .full(full6)
`ifdef FACTORY_ALLOC_STATS_EN
        , .stat_grants(stat_grants6), .stat_stalls(stat_stalls6)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int req;
        int id;
        int kind;
    } exp_t;

    exp_t exp_q[$];
    int   ack_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every ack cycle must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (req_ack !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(req_ack), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_onehot", 32'(req_ack), 32'(4'b0001 << e.req));
                check("gnt_id", 32'(gnt_id), 32'(e.id));
                check("gnt_kind", 32'(gnt_kind), 32'(e.kind));
            end
            ack_cyc.push_back(cyc);
        end
    end

    task automatic push_exp(input int r, input int id, input int k);
        exp_t e;
        e.req = r; e.id = id; e.kind = k;
        exp_q.push_back(e);
    endtask

    // A requester drops its request right after seeing its ack.
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~req_ack;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_kind = 8'b00_11_01_10;
        rel_valid = 1'b0; rel_id = '0; qry_id = '0;
        rel_valid6 = 1'b0; rel_id6 = '0;
        do_reset();

        // Reset state
        check("rst_free_count", 32'(free_count), 32'd8);
        check("rst_full", 32'(full), 32'd0);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_gnt_kind", 32'(gnt_kind), 32'd0);
        check("rst_rel_err", 32'(rel_err), 32'd0);
        check("rst_qry_used", 32'(qry_used), 32'd0);
`ifdef FACTORY_ALLOC_STATS_EN
        check("rst_stat_grants", 32'(stat_grants), 32'd0);
`endif

        // Test 1: single request from requester 0, kind 2
        push_exp(0, 0, 2);
        req_valid = 4'b0001;
        step();
        check("t1_ack_latency", 32'(req_ack), 32'b0001);
        step();
        qry_id = 3'd0;
        #1;
        check("t1_free_count", 32'(free_count), 32'd7);
        check("t1_qry_used", 32'(qry_used), 32'd1);
        check("t1_qry_kind", 32'(qry_kind), 32'd2);

        // Test 2: all four request together from a fresh reset
        do_reset();
        ack_cyc.delete();
        push_exp(0, 0, 2); push_exp(1, 1, 1); push_exp(2, 2, 3); push_exp(3, 3, 0);
        req_valid = 4'b1111;
        run(10);
        check("t2_pending", 32'(exp_q.size()), 32'd0);
        check("t2_free_count", 32'(free_count), 32'd4);
        check("t2_ack_count", 32'(ack_cyc.size()), 32'd4);
        if (ack_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                check("t2_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);

        // Test 3: fill the pool, stall while full, then release slot 5
        push_exp(0, 4, 2); push_exp(1, 5, 1); push_exp(2, 6, 3); push_exp(3, 7, 0);
        req_valid = 4'b1111;
        run(10);
        check("t3_fill_pending", 32'(exp_q.size()), 32'd0);
        check("t3_full", 32'(full), 32'd1);
        check("t3_free_zero", 32'(free_count), 32'd0);
        req_valid = 4'b0010;
        run(4);
        check("t3_still_full", 32'(full), 32'd1);
        check("t3_req_waiting", 32'(req_valid), 32'b0010);
`ifdef FACTORY_ALLOC_STATS_EN
        check("t3_stat_stalls", 32'(stat_stalls), 32'd4);
`endif
        push_exp(1, 5, 1);
        rel_valid = 1'b1; rel_id = 3'd5;
        step();
        rel_valid = 1'b0;
        check("t3_no_early_ack", 32'(req_ack), 32'd0);
        check("t3_free_after_rel", 32'(free_count), 32'd1);
        step();
        check("t3_regrant_ack", 32'(req_ack), 32'b0010);
        step();
        check("t3_refull", 32'(full), 32'd1);
        check("t3_pending", 32'(exp_q.size()), 32'd0);
`ifdef FACTORY_ALLOC_STATS_EN
        check("t3_stat_grants", 32'(stat_grants), 32'd9);
`endif

        // Test 4: valid release of slot 3, then a second release of the now-free slot
        rel_valid = 1'b1; rel_id = 3'd3;
        step();
        check("t4_good_rel_err", 32'(rel_err), 32'd0);
        check("t4_good_rel_free", 32'(free_count), 32'd1);
        step();
        rel_valid = 1'b0;
        check("t4_dup_rel_err", 32'(rel_err), 32'd1);
        check("t4_dup_rel_free", 32'(free_count), 32'd1);
        step();
        check("t4_rel_err_pulse", 32'(rel_err), 32'd0);
        qry_id = 3'd3;
        #1;
        check("t4_qry_freed", 32'({qry_used, qry_kind}), 32'd0);
        // Out-of-range and free-slot releases on the 6-slot pool
        rel_valid6 = 1'b1; rel_id6 = 3'd7;
        step();
        check("t4_oor_rel_err", 32'(rel_err6), 32'd1);
        rel_id6 = 3'd2;
        step();
        rel_valid6 = 1'b0;
        check("t4_free6_rel_err", 32'(rel_err6), 32'd1);
        check("t4_free_count6", 32'(free_count6), 32'd6);
        step();
        check("t4_rel_err6_pulse", 32'(rel_err6), 32'd0);

        // Test 5: release slot 0 in the same cycle slot 2 is committed
        do_reset();
        push_exp(0, 0, 2); push_exp(1, 1, 1);
        req_valid = 4'b0011;
        run(6);
        check("t5_setup_free", 32'(free_count), 32'd6);
        push_exp(2, 2, 3);
        req_valid = 4'b0100;
        step();
        check("t5_in_grant", 32'(req_ack), 32'b0100);
        rel_valid = 1'b1; rel_id = 3'd0;
        step();
        rel_valid = 1'b0;
        check("t5_net_zero", 32'(free_count), 32'd6);
        check("t5_rel_ok", 32'(rel_err), 32'd0);
        push_exp(3, 0, 0);
        req_valid = 4'b1000;
        run(4);
        check("t5_pending", 32'(exp_q.size()), 32'd0);
        check("t5_free_count", 32'(free_count), 32'd5);

        // Test 6: reset during the grant cycle
        do_reset();
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_ack_suppressed", 32'(req_ack), 32'd0);
        req_valid = 4'b0000;
        step();
        rst = 1'b0;
        qry_id = 3'd0;
        #1;
        check("t6_free_count", 32'(free_count), 32'd8);
        check("t6_slot_free", 32'(qry_used), 32'd0);
`ifdef FACTORY_ALLOC_STATS_EN
        check("t6_stat_grants", 32'(stat_grants), 32'd0);
`endif
        run(3);
        check("t6_final_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
